// File: rtl/mem_bus_ctrl.sv
// RV32I load/store sequencer between the core and a single-port SRAM with programmable wait states.
// Latency: request edge to mem_rdy_o is WAIT_STATES+3 cycles, misalign_o after 1; no backpressure, requests outside IDLE are dropped.
module mem_bus_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int WORD_ADDR_WIDTH = 10,
    parameter int WAIT_STATES     = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       mrd_i,
    input  logic                       mwr_i,
    input  logic [31:0]                byte_addr_i,
    input  logic [2:0]                 funct3_i,
    input  logic [DATA_WIDTH-1:0]      wd_i,
    output logic [DATA_WIDTH-1:0]      rd_o,
    output logic                       mem_busy_o,
    output logic                       mem_rdy_o,
    output logic                       misalign_o,
    output logic [WORD_ADDR_WIDTH-1:0] sram_addr_o,
    output logic                       sram_re_o,
    output logic                       sram_we_o,
    output logic [3:0]                 sram_be_o,
    output logic [DATA_WIDTH-1:0]      sram_wd_o,
    input  logic [DATA_WIDTH-1:0]      sram_rd_i
);

    localparam int AW = WORD_ADDR_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [2:0]            f3_q, f3_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic                  err_q, err_d;

    logic                  req_illegal;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_ext;
    logic [DATA_WIDTH-1:0] st_wd;
    logic [3:0]            st_be;
    logic                  unused_addr_hi;

    // Only the SRAM-visible part of the byte address is kept.
    assign unused_addr_hi = ^byte_addr_i[31:AW];

    always_comb begin
        req_illegal = 1'b0;
        if (mwr_i) begin
            case (funct3_i)
                3'b000:  req_illegal = 1'b0;
                3'b001:  req_illegal = byte_addr_i[0];
                3'b010:  req_illegal = |byte_addr_i[1:0];
                default: req_illegal = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                3'b000, 3'b100: req_illegal = 1'b0;
                3'b001, 3'b101: req_illegal = byte_addr_i[0];
                3'b010:         req_illegal = |byte_addr_i[1:0];
                default:        req_illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        ld_byte = 8'(sram_rd_i >> {addr_q[1:0], 3'b000});
        ld_half = addr_q[1] ? sram_rd_i[31:16] : sram_rd_i[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = sram_rd_i;
        endcase
    end

    // Store data is replicated across lanes so the SRAM never needs a shifter.
    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                st_be = 4'b0001 << addr_q[1:0];
                st_wd = {4{wd_q[7:0]}};
            end
            2'b01: begin
                st_be = addr_q[1] ? 4'b1100 : 4'b0011;
                st_wd = {2{wd_q[15:0]}};
            end
            default: begin
                st_be = 4'b1111;
                st_wd = wd_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (mwr_i || mrd_i) begin
                    addr_d  = byte_addr_i[AW-1:0];
                    f3_d    = funct3_i;
                    wd_d    = wd_i;
                    wr_d    = mwr_i;
                    err_d   = req_illegal;
                    state_d = req_illegal ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = 4'(WAIT_STATES);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (!wr_q) begin
                        rd_d = ld_ext;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            f3_q    <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    // All handshake outputs decode from state so reset clears them without a clock.
    assign mem_busy_o  = (state_q == ISSUE) || (state_q == WAIT);
    assign mem_rdy_o   = (state_q == DONE) && !err_q;
    assign misalign_o  = (state_q == DONE) && err_q;
    assign sram_re_o   = (state_q == ISSUE) && !wr_q;
    assign sram_we_o   = (state_q == ISSUE) && wr_q;
    assign sram_be_o   = (state_q == ISSUE) ? st_be : 4'b0000;
    assign sram_wd_o   = st_wd;
    assign sram_addr_o = addr_q[AW-1:2];
    assign rd_o        = rd_q;

endmodule
